// File: rtl/lfsr_bist_sequencer.sv
// BIST sequencer for a PRBS8 Galois LFSR generator/checker pair: seeds the pair,
// waits for lock, soaks, injects corruption, then confirms unlock and relock.
module lfsr_bist_sequencer #(
  parameter int SEED_W         = 8,
  parameter int SOFT_RST_CYC   = 2,
  parameter int LOCK_TIMEOUT   = 64,
  parameter int RUN_LEN        = 256,
  parameter int CORRUPT_LEN    = 3,
  parameter int UNLOCK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [SEED_W-1:0] i_seed,
  input  logic              i_lock,
  output logic [SEED_W-1:0] o_seed,
  output logic              o_soft_reset,
  output logic              o_valid,
  output logic              o_corrupt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [2:0]        o_err_code
);

  localparam int M_A   = (LOCK_TIMEOUT > RUN_LEN) ? LOCK_TIMEOUT : RUN_LEN;
  localparam int M_B   = (CORRUPT_LEN > UNLOCK_TIMEOUT) ? CORRUPT_LEN : UNLOCK_TIMEOUT;
  localparam int M_C   = (M_B > SOFT_RST_CYC) ? M_B : SOFT_RST_CYC;
  localparam int MAX_P = (M_A > M_C) ? M_A : M_C;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_WAIT_LOCK, S_RUN, S_INJECT, S_WAIT_UNLOCK, S_WAIT_RELOCK, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_dec;
  logic [SEED_W-1:0]  seed_q, seed_d;
  logic               pass_q, pass_d;
  logic [2:0]         err_q, err_d;
  logic               soft_reset_q, soft_reset_d;
  logic               valid_q, valid_d;
  logic               corrupt_q, corrupt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  assign cnt_dec = cnt_q - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    pass_d  = pass_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          seed_d = i_seed;
          pass_d = 1'b0;
          err_d  = 3'd0;
          // An all-zero seed would lock the LFSR up, so fail without touching it.
          if (i_seed == '0) begin
            state_d = S_DONE;
            err_d   = 3'd5;
          end else begin
            state_d = S_SEED;
            cnt_d   = CNT_W'(SOFT_RST_CYC - 1);
          end
        end
      end
      S_SEED: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_WAIT_LOCK: begin
        if (i_lock) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(RUN_LEN - 1);
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          err_d   = 3'd1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_RUN: begin
        if (!i_lock) begin
          state_d = S_DONE;
          err_d   = 3'd2;
        end else if (cnt_q == '0) begin
          state_d = S_INJECT;
          cnt_d   = CNT_W'(CORRUPT_LEN - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_INJECT: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_UNLOCK;
          cnt_d   = CNT_W'(UNLOCK_TIMEOUT - 1);
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_WAIT_UNLOCK: begin
        if (!i_lock) begin
          state_d = S_WAIT_RELOCK;
          cnt_d   = CNT_W'(LOCK_TIMEOUT - 1);
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          err_d   = 3'd3;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_WAIT_RELOCK: begin
        if (i_lock) begin
          state_d = S_DONE;
          err_d   = 3'd0;
          pass_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
          err_d   = 3'd4;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort discards any verdict reached this cycle; the last result stays visible.
    if (state_q != S_IDLE && i_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      seed_d  = '0;
      pass_d  = pass_q;
      err_d   = err_q;
    end
    soft_reset_d = (state_d == S_SEED);
    valid_d      = (state_d == S_WAIT_LOCK) || (state_d == S_RUN) || (state_d == S_INJECT) ||
                   (state_d == S_WAIT_UNLOCK) || (state_d == S_WAIT_RELOCK);
    corrupt_d    = (state_d == S_INJECT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      seed_q       <= '0;
      pass_q       <= 1'b0;
      err_q        <= 3'd0;
      soft_reset_q <= 1'b0;
      valid_q      <= 1'b0;
      corrupt_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seed_q       <= seed_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      soft_reset_q <= soft_reset_d;
      valid_q      <= valid_d;
      corrupt_q    <= corrupt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_seed       = seed_q;
  assign o_soft_reset = soft_reset_q;
  assign o_valid      = valid_q;
  assign o_corrupt    = corrupt_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_code   = err_q;

endmodule

// File: tb/tb_lfsr_bist_sequencer.sv
// Scoreboard bench for lfsr_bist_sequencer: a phase-walking reference model predicts each
// run's verdict, timing and strobe counts; a negedge monitor checks them on every o_done.
module tb_lfsr_bist_sequencer;
  localparam int T_SEED = 2, T_LOCK = 64, T_RUN = 256, T_CORR = 3, T_UNLOCK = 8;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_start = 1'b0, i_abort = 1'b0, i_lock = 1'b0;
  logic [7:0] i_seed = 8'h00;
  logic [7:0] o_seed;
  logic       o_soft_reset, o_valid, o_corrupt, o_busy, o_done, o_pass;
  logic [2:0] o_err_code;

  lfsr_bist_sequencer dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_seed(i_seed),
    .i_lock(i_lock), .o_seed(o_seed), .o_soft_reset(o_soft_reset), .o_valid(o_valid),
    .o_corrupt(o_corrupt), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seed;
    int         done_k;
    logic       pass;
    logic [2:0] err;
    int         n_srst;
    int         n_valid;
    int         n_corr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_pass = 0;
  int   busy_cyc = 0, cnt_s = 0, cnt_v = 0, cnt_c = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Lock profile: high in [l1,u0) and from u1 onward, forced low in cycle g.
  function automatic bit lock_at(input int k, input int l1, input int u0, input int u1, input int g);
    if (k == g) return 1'b0;
    return (k >= l1 && k < u0) || (k >= u1);
  endfunction

  // Walks the test phases over the lock profile; k counts cycles after start acceptance.
  function automatic exp_t model(input logic [7:0] seed, input int l1, input int u0,
                                 input int u1, input int g);
    exp_t e;
    int   t;
    bit   hit;
    e.seed = seed; e.pass = 1'b0; e.n_corr = 0; e.err = 3'd0;
    if (seed == 8'h00) begin
      e.done_k = 0; e.err = 3'd5; e.n_srst = 0; e.n_valid = 0;
      return e;
    end
    e.n_srst = T_SEED;
    t = T_SEED; hit = 1'b0;
    for (int i = 0; i < T_LOCK && !hit; i++)
      if (lock_at(t + i, l1, u0, u1, g)) begin hit = 1'b1; t = t + i + 1; end
    if (!hit) begin
      e.done_k = t + T_LOCK; e.err = 3'd1; e.n_valid = e.done_k - T_SEED;
      return e;
    end
    for (int i = 0; i < T_RUN; i++)
      if (!lock_at(t + i, l1, u0, u1, g)) begin
        e.done_k = t + i + 1; e.err = 3'd2; e.n_valid = e.done_k - T_SEED;
        return e;
      end
    t = t + T_RUN + T_CORR;
    e.n_corr = T_CORR;
    hit = 1'b0;
    for (int i = 0; i < T_UNLOCK && !hit; i++)
      if (!lock_at(t + i, l1, u0, u1, g)) begin hit = 1'b1; t = t + i + 1; end
    if (!hit) begin
      e.done_k = t + T_UNLOCK; e.err = 3'd3; e.n_valid = e.done_k - T_SEED;
      return e;
    end
    for (int i = 0; i < T_LOCK; i++)
      if (lock_at(t + i, l1, u0, u1, g)) begin
        e.done_k = t + i + 1; e.pass = 1'b1; e.n_valid = e.done_k - T_SEED;
        return e;
      end
    e.done_k = t + T_LOCK; e.err = 3'd4; e.n_valid = e.done_k - T_SEED;
    return e;
  endfunction

  // Monitor: counts strobes over the busy window and scores each o_done.
  always @(negedge clk) begin
    if (o_done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: o_done with err %0d, required no pending run", o_err_code);
      end else begin
        mon_e = sb_q.pop_front();
        $display("run seed=%02h: done_k=%0d err=%0d pass=%0d (expected %0d/%0d/%0d)",
                 mon_e.seed, busy_cyc, o_err_code, o_pass, mon_e.done_k, mon_e.err, mon_e.pass);
        check("done_latency", busy_cyc, mon_e.done_k);
        check("err_code", int'(o_err_code), int'(mon_e.err));
        check("pass", int'(o_pass), int'(mon_e.pass));
        check("seed_out", int'(o_seed), int'(mon_e.seed));
        check("soft_reset_cycles", cnt_s, mon_e.n_srst);
        check("valid_cycles", cnt_v, mon_e.n_valid);
        check("corrupt_cycles", cnt_c, mon_e.n_corr);
        check("valid_in_done", int'(o_valid), 0);
      end
    end
    if (o_busy && !o_done) begin
      busy_cyc++;
      cnt_s += int'(o_soft_reset);
      cnt_v += int'(o_valid);
      cnt_c += int'(o_corrupt);
    end else begin
      busy_cyc = 0; cnt_s = 0; cnt_v = 0; cnt_c = 0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_seed"}, int'(o_seed), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_soft_reset"}, int'(o_soft_reset), 0);
    check({tag, "_corrupt"}, int'(o_corrupt), 0);
    check({tag, "_done"}, int'(o_done), 0);
  endtask

  task automatic run_txn(input logic [7:0] seed, input int l1, input int u0, input int u1,
                         input int g, input bit abort_with_start, input bit late_start);
    exp_t e;
    e = model(seed, l1, u0, u1, g);
    sb_q.push_back(e);
    @(negedge clk);
    i_seed = seed; i_start = 1'b1; i_abort = abort_with_start;
    for (int k = 0; k <= e.done_k; k++) begin
      @(negedge clk);
      i_start = 1'b0; i_abort = 1'b0;
      i_lock  = lock_at(k, l1, u0, u1, g);
      if (k == 0 && seed != 8'h00) begin
        check("start_clears_err", int'(o_err_code), 0);
        check("start_clears_pass", int'(o_pass), 0);
        check("soft_reset_first_cycle", int'(o_soft_reset), 1);
      end
      if (late_start && k == 10 && e.done_k > 11) begin
        i_start = 1'b1; i_seed = ~seed;
      end
    end
    @(negedge clk);
    i_lock = 1'b0; i_start = 1'b0;
    for (int w = 0; w < 700 && o_busy; w++) @(negedge clk);
    check("back_to_idle", int'(o_busy), 0);
    if (o_busy) begin
      i_rst = 1'b1; @(negedge clk); i_rst = 1'b0;
      sb_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_err", int'(o_err_code), 0);
    check("reset_pass", int'(o_pass), 0);
    i_rst = 1'b0;
    @(negedge clk);

    run_txn(8'hAA, 7, 268, 272, -1, 1'b0, 1'b1);        // full pass sequence
    run_txn(8'h5C, 1000, 1000, 1000, -1, 1'b0, 1'b0);   // never locks
    check("err_held_idle", int'(o_err_code), 1);
    run_txn(8'h3C, 7, 1000, 1000, 108, 1'b0, 1'b0);     // lock glitch at RUN cycle 100
    run_txn(8'h81, 2, 1000, 1000, -1, 1'b0, 1'b0);      // stuck lock, no unlock
    run_txn(8'h00, 2, 1000, 1000, -1, 1'b0, 1'b0);      // zero seed
    run_txn(8'h17, 7, 268, 1000, -1, 1'b1, 1'b0);       // no relock; abort loses to start
    run_txn(8'h42, 65, 1000, 1000, -1, 1'b0, 1'b0);     // lock on last WAIT_LOCK cycle
    run_txn(8'h43, 66, 1000, 1000, -1, 1'b0, 1'b0);     // lock one cycle too late
    run_txn(8'h44, 2, 269, 280, -1, 1'b0, 1'b0);        // unlock on last allowed cycle
    run_txn(8'h45, 2, 270, 280, -1, 1'b0, 1'b0);        // unlock one cycle too late

    for (int r = 0; r < 10; r++) begin
      int l1, u0, u1, g;
      logic [7:0] sd;
      sd = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      l1 = $urandom_range(2, 70);
      u0 = l1 + 1 + T_RUN + T_CORR + $urandom_range(0, 10);
      u1 = u0 + $urandom_range(1, 70);
      g  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 340) : -1;
      run_txn(sd, l1, u0, u1, g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Synchronous reset in the middle of RUN.
    @(negedge clk);
    i_seed = 8'h33; i_start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_lock  = lock_at(k, 7, 1000, 1000, -1);
    end
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0; i_lock = 1'b0;
    check_all_zero("mid_run_reset");
    check("mid_run_reset_err", int'(o_err_code), 0);
    $display("mid-run reset: busy=%0d seed=%02h", o_busy, o_seed);

    // Abort while waiting for lock after a failed run: no o_done, verdict regs untouched.
    run_txn(8'h5C, 1000, 1000, 1000, -1, 1'b0, 1'b0);
    @(negedge clk);
    i_seed = 8'h66; i_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    check("abort_precheck_busy", int'(o_busy), 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check_all_zero("abort");
    check("abort_err_kept", int'(o_err_code), 0);
    check("abort_pass_kept", int'(o_pass), 0);
    repeat (4) @(negedge clk);
    check("abort_no_done", int'(o_done), 0);
    $display("abort: busy=%0d err=%0d", o_busy, o_err_code);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
